// File: rtl/mfp_ahb_bot_upd_handshake_pkg.sv
// Shared constants for the Rojobot update handshake stage.
package mfp_ahb_bot_upd_handshake_pkg;

    // Handshake states; H_BOT_UPDATE_SYNC is high only in BOTHS_PENDING.
    typedef enum logic [1:0] {
        BOTHS_IDLE    = 2'd0,
        BOTHS_PENDING = 2'd1,
        BOTHS_ACK_HI  = 2'd2
    } boths_state_t;

    // Two flops is enough for a slow robot strobe entering the HCLK domain.
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Width of the robot info word.
    localparam int BOT_INFO_W = 32;

endpackage

// File: rtl/mfp_ahb_bot_upd_handshake_if.sv
// Robot-side and I/O-block-side signals of the update handshake stage.
interface mfp_ahb_bot_upd_handshake_if #(
    parameter int CNT_W = 8
);
    logic             BOT_UPD;
    logic [31:0]      BOT_INFO_IN;
    logic             H_INT_ACK;
    logic             CNT_CLR;
    logic [31:0]      H_BOT_INFO;
    logic             H_BOT_UPDATE_SYNC;
    logic             BOT_IRQ;
    logic [CNT_W-1:0] BOT_OVERRUN_CNT;

    // Drives the strobe, info word, ack and clear; observes the results.
    modport master (
        output BOT_UPD, BOT_INFO_IN, H_INT_ACK, CNT_CLR,
        input  H_BOT_INFO, H_BOT_UPDATE_SYNC, BOT_IRQ, BOT_OVERRUN_CNT
    );

    // The handshake stage itself.
    modport slave (
        input  BOT_UPD, BOT_INFO_IN, H_INT_ACK, CNT_CLR,
        output H_BOT_INFO, H_BOT_UPDATE_SYNC, BOT_IRQ, BOT_OVERRUN_CNT
    );
endinterface

// File: rtl/mfp_ahb_bot_upd_handshake_sync_edge.sv
// mfp_sync_edge: N-flop synchronizer with a one-cycle rising-edge pulse.
// Also usable for the switch and pushbutton inputs.
module mfp_sync_edge #(
    parameter int N = 2
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic d,
    output logic rise
);

    logic [N-1:0] sync_reg;
    logic         last_reg;

    // Shift the raw input through the chain; keep a delayed copy of the last stage.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_reg <= '0;
            last_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[N-2:0], d};
            last_reg <= sync_reg[N-1];
        end
    end

    assign rise = sync_reg[N-1] & ~last_reg;

endmodule

// File: rtl/mfp_ahb_bot_upd_handshake.sv
// Rojobot update handshake: synchronizes BOT_UPD, snapshots BOT_INFO_IN,
// raises the pending flag/IRQ and tracks updates lost before software acks.
module mfp_ahb_bot_upd_handshake
    import mfp_ahb_bot_upd_handshake_pkg::*;
#(
    parameter int SYNC_STAGES          = DEFAULT_SYNC_STAGES,
    parameter bit OVERWRITE_ON_OVERRUN = 1'b1,
    parameter int CNT_W                = 8
) (
    input logic                         HCLK,
    input logic                         HRESETn,
    mfp_ahb_bot_upd_handshake_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    boths_state_t          state_reg, state_next;
    logic                  deferred_reg, deferred_next;
    logic                  ack_d_reg;
    logic                  upd_evt, ack_rise;
    logic                  capture, overrun, irq_next;
    logic [BOT_INFO_W-1:0] info_reg;
    logic                  pending_reg;
    logic                  irq_reg;
    logic [CNT_W-1:0]      cnt_reg;

    mfp_sync_edge #(.N(SYNC_STAGES)) u_upd_sync (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .d       (bus.BOT_UPD),
        .rise    (upd_evt)
    );

    // H_INT_ACK is already an HCLK register, so no synchronizer in front.
    assign ack_rise = bus.H_INT_ACK & ~ack_d_reg;

    // State register, deferred-update flag and ack history.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg    <= BOTHS_IDLE;
            deferred_reg <= 1'b0;
            ack_d_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            deferred_reg <= deferred_next;
            ack_d_reg    <= bus.H_INT_ACK;
        end
    end

    // Next state: an update seen while ack is still high is remembered and
    // re-presented once software drops ack.
    always_comb begin
        state_next    = state_reg;
        deferred_next = deferred_reg;
        case (state_reg)
            BOTHS_IDLE: begin
                if (upd_evt) state_next = BOTHS_PENDING;
            end
            BOTHS_PENDING: begin
                if (ack_rise) begin
                    state_next    = BOTHS_ACK_HI;
                    deferred_next = upd_evt;
                end
            end
            BOTHS_ACK_HI: begin
                if (!bus.H_INT_ACK) begin
                    state_next    = (deferred_reg | upd_evt) ? BOTHS_PENDING : BOTHS_IDLE;
                    deferred_next = 1'b0;
                end else begin
                    deferred_next = deferred_reg | upd_evt;
                end
            end
            default: begin
                state_next    = BOTHS_IDLE;
                deferred_next = 1'b0;
            end
        endcase
    end

    // Output decode: when to capture the info word and when an update is lost.
    always_comb begin
        capture = 1'b0;
        overrun = 1'b0;
        case (state_reg)
            BOTHS_IDLE: begin
                capture = upd_evt;
            end
            BOTHS_PENDING: begin
                if (upd_evt) begin
                    if (ack_rise) begin
                        capture = 1'b1;
                    end else begin
                        overrun = 1'b1;
                        capture = OVERWRITE_ON_OVERRUN;
                    end
                end
            end
            BOTHS_ACK_HI: begin
                if (upd_evt) begin
                    if (deferred_reg) begin
                        overrun = 1'b1;
                        capture = OVERWRITE_ON_OVERRUN;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            default: begin
                capture = 1'b0;
                overrun = 1'b0;
            end
        endcase
        irq_next = (state_next == BOTHS_PENDING) && (state_reg != BOTHS_PENDING);
    end

    // Registered outputs: snapshot, pending flag, IRQ pulse, saturating counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            info_reg    <= '0;
            pending_reg <= 1'b0;
            irq_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            if (capture) info_reg <= bus.BOT_INFO_IN;
            pending_reg <= (state_next == BOTHS_PENDING);
            irq_reg     <= irq_next;
            if (bus.CNT_CLR) begin
                cnt_reg <= '0;
            end else if (overrun && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign bus.H_BOT_INFO        = info_reg;
    assign bus.H_BOT_UPDATE_SYNC = pending_reg;
    assign bus.BOT_IRQ           = irq_reg;
    assign bus.BOT_OVERRUN_CNT   = cnt_reg;

endmodule

// File: tb/tb_mfp_ahb_bot_upd_handshake.sv
// Testbench: two instances (overwrite on / off) driven identically and
// checked every cycle against a behavioural model, plus directed checks.
module tb_mfp_ahb_bot_upd_handshake;

    localparam int N       = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        upd = 1'b0;
    logic        ack = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] info = '0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_bot_upd_handshake_if #(.CNT_W(CNT_W)) bus_ow0 ();
    mfp_ahb_bot_upd_handshake_if #(.CNT_W(CNT_W)) bus_ow1 ();

    assign bus_ow0.BOT_UPD     = upd;
    assign bus_ow0.BOT_INFO_IN = info;
    assign bus_ow0.H_INT_ACK   = ack;
    assign bus_ow0.CNT_CLR     = clr;
    assign bus_ow1.BOT_UPD     = upd;
    assign bus_ow1.BOT_INFO_IN = info;
    assign bus_ow1.H_INT_ACK   = ack;
    assign bus_ow1.CNT_CLR     = clr;

    mfp_ahb_bot_upd_handshake #(
        .SYNC_STAGES(N), .OVERWRITE_ON_OVERRUN(1'b0), .CNT_W(CNT_W)
    ) dut_ow0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_ow0));

    mfp_ahb_bot_upd_handshake #(
        .SYNC_STAGES(N), .OVERWRITE_ON_OVERRUN(1'b1), .CNT_W(CNT_W)
    ) dut_ow1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_ow1));

    int checks = 0;
    int passes = 0;

    // Model: index 0 = snapshot keeps first value, index 1 = overrun refreshes.
    bit          m_flag[2];      // software sees an update pending
    bit          m_waiting[2];   // software has acked, ack still high
    bit          m_queued[2];    // an update arrived during the ack phase
    bit          m_irq[2];
    logic [31:0] m_info[2];
    int          m_cnt[2];
    bit          hist[$];        // BOT_UPD value sampled at each edge
    bit          ack_prev;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < N + 2; i++) hist.push_back(1'b0);
        ack_prev = 1'b0;
        for (int v = 0; v < 2; v++) begin
            m_flag[v] = 0; m_waiting[v] = 0; m_queued[v] = 0;
            m_irq[v] = 0; m_info[v] = '0; m_cnt[v] = 0;
        end
    endtask

    // True when the next edge sees a synchronized BOT_UPD rise: the strobe
    // was 1 exactly N edges earlier and 0 the edge before that.
    function automatic bit evt_next();
        return hist[hist.size() - N] && !hist[hist.size() - N - 1];
    endfunction

    task automatic model_edge();
        bit e;
        bit ar;
        bit lost;
        e  = evt_next();
        ar = ack && !ack_prev;
        for (int v = 0; v < 2; v++) begin
            lost     = 1'b0;
            m_irq[v] = 1'b0;
            if (m_flag[v]) begin
                if (ar) begin
                    m_flag[v]    = 0;
                    m_waiting[v] = 1;
                    if (e) begin m_info[v] = info; m_queued[v] = 1; end
                end else if (e) begin
                    lost = 1'b1;
                    if (v == 1) m_info[v] = info;
                end
            end else if (m_waiting[v]) begin
                if (e) begin
                    if (m_queued[v]) begin
                        lost = 1'b1;
                        if (v == 1) m_info[v] = info;
                    end else begin
                        m_info[v]   = info;
                        m_queued[v] = 1;
                    end
                end
                if (!ack) begin
                    m_waiting[v] = 0;
                    if (m_queued[v]) begin
                        m_queued[v] = 0;
                        m_flag[v]   = 1;
                        m_irq[v]    = 1;
                    end
                end
            end else if (e) begin
                m_info[v] = info;
                m_flag[v] = 1;
                m_irq[v]  = 1;
            end
            if (clr) m_cnt[v] = 0;
            else if (lost && m_cnt[v] < CNT_MAX) m_cnt[v] = m_cnt[v] + 1;
        end
        hist.push_back(upd);
        if (hist.size() > 16) void'(hist.pop_front());
        ack_prev = ack;
    endtask

    task automatic compare_all(string tag);
        chk({tag, " ow0.info"}, bus_ow0.H_BOT_INFO, m_info[0]);
        chk({tag, " ow0.sync"}, {31'b0, bus_ow0.H_BOT_UPDATE_SYNC}, {31'b0, m_flag[0]});
        chk({tag, " ow0.irq"},  {31'b0, bus_ow0.BOT_IRQ}, {31'b0, m_irq[0]});
        chk({tag, " ow0.cnt"},  {24'b0, bus_ow0.BOT_OVERRUN_CNT}, 32'(m_cnt[0]));
        chk({tag, " ow1.info"}, bus_ow1.H_BOT_INFO, m_info[1]);
        chk({tag, " ow1.sync"}, {31'b0, bus_ow1.H_BOT_UPDATE_SYNC}, {31'b0, m_flag[1]});
        chk({tag, " ow1.irq"},  {31'b0, bus_ow1.BOT_IRQ}, {31'b0, m_irq[1]});
        chk({tag, " ow1.cnt"},  {24'b0, bus_ow1.BOT_OVERRUN_CNT}, 32'(m_cnt[1]));
    endtask

    // Drive one cycle of inputs, clock it, then check 1 ns after the edge.
    task automatic step(string tag, bit u, logic [31:0] i, bit a, bit c);
        upd = u; info = i; ack = a; clr = c;
        @(posedge HCLK);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " ow0.info"}, bus_ow0.H_BOT_INFO, 32'h0);
        chk({tag, " ow0.sync"}, {31'b0, bus_ow0.H_BOT_UPDATE_SYNC}, 32'h0);
        chk({tag, " ow0.irq"},  {31'b0, bus_ow0.BOT_IRQ}, 32'h0);
        chk({tag, " ow0.cnt"},  {24'b0, bus_ow0.BOT_OVERRUN_CNT}, 32'h0);
        chk({tag, " ow1.info"}, bus_ow1.H_BOT_INFO, 32'h0);
        chk({tag, " ow1.sync"}, {31'b0, bus_ow1.H_BOT_UPDATE_SYNC}, 32'h0);
        chk({tag, " ow1.irq"},  {31'b0, bus_ow1.BOT_IRQ}, 32'h0);
        chk({tag, " ow1.cnt"},  {24'b0, bus_ow1.BOT_OVERRUN_CNT}, 32'h0);
    endtask

    initial begin
        int irq_seen;
        bit ru, ra;

        // Power-on reset
        model_reset();
        repeat (2) @(posedge HCLK);
        #1;
        chk_all_zero("reset");
        #3 HRESETn = 1'b1;

        // 1: BOT_UPD held high 10 cycles -> one event at edge k+2
        irq_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step("t1", 1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
            if (bus_ow1.BOT_IRQ) irq_seen++;
            if (k == 1) chk("t1 sync_k+1", {31'b0, bus_ow1.H_BOT_UPDATE_SYNC}, 32'h0);
            if (k == 2) begin
                chk("t1 sync_k+2", {31'b0, bus_ow1.H_BOT_UPDATE_SYNC}, 32'h1);
                chk("t1 irq_k+2",  {31'b0, bus_ow1.BOT_IRQ}, 32'h1);
            end
        end
        chk("t1 info", bus_ow1.H_BOT_INFO, 32'hA5A5_0001);
        chk("t1 irq_count", 32'(irq_seen), 32'd1);
        step("t1", 1'b0, 32'hA5A5_0001, 1'b0, 1'b0);

        // 2: ack rise drops the flag; ack released with nothing queued -> idle
        step("t2", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("t2 sync_on_ack", {31'b0, bus_ow1.H_BOT_UPDATE_SYNC}, 32'h0);
        repeat (4) step("t2", 1'b0, 32'h0, 1'b1, 1'b0);
        step("t2", 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) step("t2", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t2 sync_idle", {31'b0, bus_ow1.H_BOT_UPDATE_SYNC}, 32'h0);
        chk("t2 cnt", {24'b0, bus_ow1.BOT_OVERRUN_CNT}, 32'h0);

        // 3: overrun while pending
        repeat (3) step("t3", 1'b1, 32'h1111_1111, 1'b0, 1'b0);
        repeat (2) step("t3", 1'b0, 32'h1111_1111, 1'b0, 1'b0);
        repeat (3) step("t3", 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        chk("t3 ow1.info", bus_ow1.H_BOT_INFO, 32'h2222_2222);
        chk("t3 ow1.cnt",  {24'b0, bus_ow1.BOT_OVERRUN_CNT}, 32'h1);
        chk("t3 ow1.irq",  {31'b0, bus_ow1.BOT_IRQ}, 32'h0);
        chk("t3 ow0.info", bus_ow0.H_BOT_INFO, 32'h1111_1111);

        // 4: ack rise and update on the same edge
        repeat (2) step("t4", 1'b0, 32'h3333_0000, 1'b0, 1'b0);
        repeat (2) step("t4", 1'b1, 32'h3333_0000, 1'b0, 1'b0);
        step("t4", 1'b1, 32'h3333_0000, 1'b1, 1'b0);
        chk("t4 sync", {31'b0, bus_ow1.H_BOT_UPDATE_SYNC}, 32'h0);
        chk("t4 cnt",  {24'b0, bus_ow1.BOT_OVERRUN_CNT}, 32'h1);
        repeat (2) step("t4", 1'b0, 32'h0, 1'b1, 1'b0);
        step("t4", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4 sync_rel", {31'b0, bus_ow1.H_BOT_UPDATE_SYNC}, 32'h1);
        chk("t4 irq_rel",  {31'b0, bus_ow1.BOT_IRQ}, 32'h1);
        chk("t4 ow1.info", bus_ow1.H_BOT_INFO, 32'h3333_0000);
        chk("t4 ow0.info", bus_ow0.H_BOT_INFO, 32'h3333_0000);
        step("t4", 1'b0, 32'h0, 1'b1, 1'b0);
        step("t4", 1'b0, 32'h0, 1'b0, 1'b0);

        // 5: saturate the counter, then clear on the same edge as an overrun
        for (int k = 0; k < 640; k++)
            step("t5", (k % 2) == 0, 32'(k), 1'b0, 1'b0);
        chk("t5 ow1.sat", {24'b0, bus_ow1.BOT_OVERRUN_CNT}, 32'hFF);
        chk("t5 ow0.sat", {24'b0, bus_ow0.BOT_OVERRUN_CNT}, 32'hFF);
        for (int k = 0; k < 4 && !evt_next(); k++)
            step("t5", (k % 2) == 0, 32'h5555_0000, 1'b0, 1'b0);
        step("t5", 1'b0, 32'h5555_0001, 1'b0, 1'b1);
        chk("t5 clr_vs_inc", {24'b0, bus_ow1.BOT_OVERRUN_CNT}, 32'h0);

        // 6: async reset while acked with a deferred update
        repeat (3) step("t6", 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) step("t6", 1'b1, 32'h6666_0000, 1'b0, 1'b0);
        step("t6", 1'b1, 32'h6666_0000, 1'b1, 1'b0);
        step("t6", 1'b0, 32'h6666_0000, 1'b1, 1'b0);
        upd = 1'b0; ack = 1'b0;
        #3 HRESETn = 1'b0;
        model_reset();
        #1;
        chk_all_zero("t6 async");
        @(posedge HCLK);
        #1;
        chk_all_zero("t6 held");
        #3 HRESETn = 1'b1;
        irq_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step("t6 post", 1'b0, 32'h0, 1'b0, 1'b0);
            if (bus_ow1.BOT_IRQ || bus_ow0.BOT_IRQ) irq_seen++;
        end
        chk("t6 no_spurious_irq", 32'(irq_seen), 32'd0);

        // Random traffic against the model
        ru = 1'b0; ra = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(2) == 0) ru = ~ru;
            if ($urandom_range(5) == 0) ra = ~ra;
            step("rand", ru, $urandom, ra, $urandom_range(39) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
